// File: rtl/fast_pkg.sv
// Shared definitions for the FAST feature path: coordinate width helper and
// the keypoint record handed to the downstream collector.
package fast_pkg;

  // Bits needed to hold coordinates 0..n-1 (at least one bit).
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KP_DATA_W = 8;
  localparam int KP_X_W    = coord_w(640);
  localparam int KP_Y_W    = coord_w(480);

  typedef struct packed {
    logic [KP_X_W-1:0]    x;
    logic [KP_Y_W-1:0]    y;
    logic [KP_DATA_W-1:0] score;
  } kp_t;

endpackage

// File: rtl/fast_nms_if.sv
// Score stream in, keypoint decisions out. The master drives scores and
// receives decisions; the slave is the NMS stage.
interface fast_nms_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int X_W = fast_pkg::coord_w(IMG_WIDTH);
  localparam int Y_W = fast_pkg::coord_w(IMG_HEIGHT);

  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] score;
  logic                  out_valid;
  logic                  is_keypoint;
  logic [X_W-1:0]        kp_x;
  logic [Y_W-1:0]        kp_y;
  logic [DATA_WIDTH-1:0] kp_score;

  modport master (
    output in_valid, in_sof, score,
    input  out_valid, is_keypoint, kp_x, kp_y, kp_score
  );

  modport slave (
    input  in_valid, in_sof, score,
    output out_valid, is_keypoint, kp_x, kp_y, kp_score
  );
endinterface

// File: rtl/fast_nms_line_buffer.sv
// One image row of scores. Asynchronous read, synchronous write, so a read
// and a write at the same address in one beat return the old contents.
module fast_nms_line_buffer import fast_pkg::*; #(
  parameter  int DEPTH      = 640,
  parameter  int DATA_WIDTH = 8,
  localparam int AW         = coord_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Store the incoming value at the current column.
  // NOTE: the array has no reset; stale rows are never used because a frame
  // must write two full rows before any window reads them.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/fast_nms.sv
// 3x3 non-maximum suppression over a raster score stream. The centre is kept
// when it beats raster-earlier neighbours strictly and raster-later ones or
// ties, so exactly one pixel of a flat plateau survives.
module fast_nms import fast_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic       clk,
  input logic       rst_n,
  fast_nms_if.slave bus
);

  localparam int X_W = coord_w(IMG_WIDTH);
  localparam int Y_W = coord_w(IMG_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  typedef logic [DATA_WIDTH-1:0] score_t;

  logic [X_W-1:0] x_q, cur_x;
  logic [Y_W-1:0] y_q, cur_y;
  score_t         lb0_rd, lb1_rd;
  score_t         win_q [3][3];
  score_t         win_n [3][3];
  score_t         centre;
  logic           keep, emit;

  logic                  out_valid_q, is_keypoint_q;
  logic [X_W-1:0]        kp_x_q;
  logic [Y_W-1:0]        kp_y_q;
  score_t                kp_score_q;

  // Position of the current beat; a start-of-frame beat is always (0,0).
  always_comb begin
    cur_x = bus.in_sof ? '0 : x_q;
    cur_y = bus.in_sof ? '0 : y_q;
  end

  // Advance the raster position on every accepted beat.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (bus.in_valid) begin
      if (cur_x == X_LAST) begin
        x_q <= '0;
        y_q <= (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
      end else begin
        x_q <= cur_x + X_W'(1);
        y_q <= cur_y;
      end
    end
  end

  // LB0 holds row y-1, LB1 holds row y-2; LB1 is refilled from LB0's old value.
  fast_nms_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb0 (
    .clk     (clk),
    .we      (bus.in_valid),
    .addr    (cur_x),
    .wr_data (bus.score),
    .rd_data (lb0_rd)
  );

  fast_nms_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb1 (
    .clk     (clk),
    .we      (bus.in_valid),
    .addr    (cur_x),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Window as it will look after this beat: shift left, append the new column.
  // NOTE: every element is assigned on every path, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_n[r][0] = win_q[r][1];
      win_n[r][1] = win_q[r][2];
    end
    win_n[0][2] = lb1_rd;
    win_n[1][2] = lb0_rd;
    win_n[2][2] = bus.score;
  end

  // Raster tie-break: strict against earlier neighbours, >= against later.
  always_comb begin
    centre = win_n[1][1];
    keep   = (centre != '0)
           && (centre >  win_n[0][0]) && (centre >  win_n[0][1])
           && (centre >  win_n[0][2]) && (centre >  win_n[1][0])
           && (centre >= win_n[1][2]) && (centre >= win_n[2][0])
           && (centre >= win_n[2][1]) && (centre >= win_n[2][2]);
    emit   = bus.in_valid && (cur_x >= X_W'(2)) && (cur_y >= Y_W'(2));
  end

  // Window registers update only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (bus.in_valid) begin
      win_q <= win_n;
    end
  end

  // Registered decision; fields hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      is_keypoint_q <= 1'b0;
      kp_x_q        <= '0;
      kp_y_q        <= '0;
      kp_score_q    <= '0;
    end else begin
      out_valid_q <= emit;
      if (emit) begin
        is_keypoint_q <= keep;
        kp_x_q        <= cur_x - X_W'(1);
        kp_y_q        <= cur_y - Y_W'(1);
        kp_score_q    <= centre;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.is_keypoint = is_keypoint_q;
  assign bus.kp_x        = kp_x_q;
  assign bus.kp_y        = kp_y_q;
  assign bus.kp_score    = kp_score_q;

endmodule

// File: tb/tb_fast_nms.sv
// Bench for fast_nms on a 16x8 image. Expected decisions come from a direct
// neighbourhood scan of the driven image in raster order.
module tb_fast_nms;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int DW    = 8;
  localparam int N_DEC = (W - 2) * (H - 2);

  typedef struct {
    int x;
    int y;
    bit kp;
    int score;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fast_nms_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  fast_nms #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   img [H][W];
  dec_t exp_q [$];
  dec_t got_q [$];
  int   lat_err;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and helpers ----------------
  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = 0;
  endtask

  task automatic random_img(input int max_val);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = int'($urandom_range(max_val));
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int cy = 1; cy < H - 1; cy++) begin
      for (int cx = 1; cx < W - 1; cx++) begin
        dec_t d;
        int   c;
        c    = img[cy][cx];
        d.x  = cx;
        d.y  = cy;
        d.score = c;
        d.kp = (c != 0);
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) begin
              if (dy < 0 || (dy == 0 && dx < 0)) d.kp = d.kp && (c >  img[cy+dy][cx+dx]);
              else                               d.kp = d.kp && (c >= img[cy+dy][cx+dx]);
            end
          end
        end
        exp_q.push_back(d);
      end
    end
  endtask

  function automatic int seq_mismatches();
    int n;
    int mm;
    n  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    mm = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                       : exp_q.size() - got_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y ||
          got_q[i].kp != exp_q[i].kp || got_q[i].score != exp_q[i].score)
        mm++;
    return mm;
  endfunction

  function automatic int count_kp();
    int n = 0;
    foreach (got_q[i]) if (got_q[i].kp) n++;
    return n;
  endfunction

  task automatic first_kp(output int kx, output int ky, output int ks);
    kx = -1; ky = -1; ks = -1;
    foreach (got_q[i]) begin
      if (got_q[i].kp && kx < 0) begin
        kx = got_q[i].x; ky = got_q[i].y; ks = got_q[i].score;
      end
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input bit v, input bit s, input int d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.score    = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    dec_t d;
    if (bus.out_valid === 1'b1) begin
      d.x     = int'(bus.kp_x);
      d.y     = int'(bus.kp_y);
      d.kp    = bus.is_keypoint;
      d.score = int'(bus.kp_score);
      got_q.push_back(d);
    end
  endtask

  // Send the first n_beats pixels of img in raster order with random idle cycles.
  // Decision presence is checked one clock after every beat and idle cycle.
  task automatic send_frame(input int gap_pct, input bit use_sof, input int n_beats);
    for (int idx = 0; idx < n_beats; idx++) begin
      int  x;
      int  y;
      bit  exp_v;
      x = idx % W;
      y = idx / W;
      while (int'($urandom_range(99)) < gap_pct) begin
        cycle(1'b0, 1'b0, 0);
        if (bus.out_valid !== 1'b0) lat_err++;
      end
      cycle(1'b1, use_sof && idx == 0, img[y][x]);
      exp_v = (x >= 2) && (y >= 2);
      if (bus.out_valid !== exp_v) lat_err++;
      capture();
    end
    cycle(1'b0, 1'b0, 0);
    if (bus.out_valid !== 1'b0) lat_err++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.score    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.is_keypoint !== 1'b0) $display("FAIL reset_is_keypoint: got %b expected 0", bus.is_keypoint);
    else n_pass++;
    n_total++;
    if (bus.kp_x !== '0) $display("FAIL reset_kp_x: got %0d expected 0", bus.kp_x);
    else n_pass++;
    n_total++;
    if (bus.kp_y !== '0) $display("FAIL reset_kp_y: got %0d expected 0", bus.kp_y);
    else n_pass++;
    n_total++;
    if (bus.kp_score !== '0) $display("FAIL reset_kp_score: got %0d expected 0", bus.kp_score);
    else n_pass++;
  endtask

  task automatic run_frame_checks(input string name, input int gap_pct, input bit use_sof);
    int mm;
    build_expected();
    got_q.delete();
    lat_err = 0;
    send_frame(gap_pct, use_sof, W * H);
    n_total++;
    if (got_q.size() != N_DEC) $display("FAIL %s_count: got %0d decisions expected %0d", name, got_q.size(), N_DEC);
    else n_pass++;
    n_total++;
    if (lat_err != 0) $display("FAIL %s_latency: got %0d misplaced out_valid cycles expected 0", name, lat_err);
    else n_pass++;
    mm = seq_mismatches();
    n_total++;
    if (mm != 0) $display("FAIL %s_sequence: got %0d mismatching decisions expected 0", name, mm);
    else n_pass++;
  endtask

  task automatic check_single_kp(input string name, input int ex, input int ey, input int es);
    int kx, ky, ks;
    n_total++;
    if (count_kp() != 1) $display("FAIL %s_kp_count: got %0d expected 1", name, count_kp());
    else n_pass++;
    first_kp(kx, ky, ks);
    n_total++;
    if (kx != ex || ky != ey || ks != es)
      $display("FAIL %s_kp_at: got (%0d,%0d) score %0d expected (%0d,%0d) score %0d", name, kx, ky, ks, ex, ey, es);
    else n_pass++;
  endtask

  task automatic test_single_peak();
    clear_img();
    img[5][5] = 50;
    run_frame_checks("single_peak", 0, 1'b1);
    check_single_kp("single_peak", 5, 5, 50);
  endtask

  task automatic test_plateau();
    clear_img();
    for (int y = 3; y <= 4; y++)
      for (int x = 3; x <= 4; x++)
        img[y][x] = 30;
    run_frame_checks("plateau", 0, 1'b1);
    check_single_kp("plateau", 3, 3, 30);
  endtask

  task automatic test_border();
    clear_img();
    img[4][0]  = 200;
    img[4][15] = 200;
    img[0][7]  = 200;
    run_frame_checks("border", 0, 1'b1);
    n_total++;
    if (count_kp() != 0) $display("FAIL border_kp_count: got %0d expected 0", count_kp());
    else n_pass++;
  endtask

  task automatic test_valid_gaps();
    clear_img();
    img[5][5] = 50;
    run_frame_checks("valid_gaps", 40, 1'b1);
    check_single_kp("valid_gaps", 5, 5, 50);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      random_img((f % 2 == 0) ? 3 : 255);
      run_frame_checks($sformatf("random%0d", f), 30, 1'b1);
    end
  endtask

  task automatic test_mid_frame_sof();
    random_img(255);
    got_q.delete();
    lat_err = 0;
    send_frame(0, 1'b1, 3 * W + 5);
    n_total++;
    if (lat_err != 0) $display("FAIL sof_frame_a_latency: got %0d misplaced cycles expected 0", lat_err);
    else n_pass++;
    clear_img();
    img[2][2] = 9;
    run_frame_checks("mid_sof", 0, 1'b1);
    check_single_kp("mid_sof", 2, 2, 9);
  endtask

  task automatic test_async_reset();
    random_img(255);
    got_q.delete();
    lat_err = 0;
    send_frame(0, 1'b1, 4 * W + 6);
    // Beat (5,4) emitted; now present (6,4) and pull reset mid-cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    bus.score    = DW'(img[4][6]);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.is_keypoint !== 1'b0 || bus.kp_x !== '0 ||
        bus.kp_y !== '0 || bus.kp_score !== '0)
      $display("FAIL async_reset_outputs: got v=%b kp=%b x=%0d y=%0d s=%0d expected all 0",
               bus.out_valid, bus.is_keypoint, bus.kp_x, bus.kp_y, bus.kp_score);
    else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    random_img(255);
    run_frame_checks("after_reset", 10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_plateau();
    test_border();
    test_valid_gaps();
    test_random_frames();
    test_mid_frame_sof();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
